// File: rtl/fir_mc_controller_if.sv
// -----------------------------------------------------------------------------
// fir_mc_controller_if
// Handshake bundle between the multi-channel FIR controller and its
// environment: the sample offer stream going in and the finished result
// stream coming out.
//
// Parameters
//   CHANNELS     number of sample channels; sets the channel field width
//
// Signals
//   in_valid     a new sample is offered (environment -> controller)
//   in_channel   channel of the offered sample (environment -> controller)
//   in_ready     controller accepts a sample this cycle (controller -> env)
//   out_ready    downstream accepts the result (environment -> controller)
//   out_valid    accumulator holds a finished result (controller -> env)
//   out_channel  channel of the finished result (controller -> env)
//
// Modports
//   master       environment side (drives offers and out_ready)
//   slave        controller side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface fir_mc_controller_if #(
    parameter int CHANNELS = 2
);
    localparam int CH_W = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

    logic            in_valid;
    logic [CH_W-1:0] in_channel;
    logic            in_ready;
    logic            out_ready;
    logic            out_valid;
    logic [CH_W-1:0] out_channel;

    modport master (
        output in_valid,
        output in_channel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_channel
    );

    modport slave (
        input  in_valid,
        input  in_channel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_channel
    );
endinterface

// File: rtl/fir_mc_controller.sv
// -----------------------------------------------------------------------------
// fir_mc_controller
// Sequencer for a time-multiplexed, multi-channel FIR filter datapath. For each
// accepted sample it pushes the sample into that channel's delay line, clears
// the accumulator, walks every tap with one multiply-accumulate per cycle and
// then presents the finished result until downstream takes it.
//
// Configuration
//   FIR_CTRL_PIPE_MAC_EN  when defined, a one-cycle DRAIN state follows the
//                         last MAC to flush a registered multiplier stage
//                         (latency TAPS+3 instead of TAPS+2).
//
// Parameters
//   TAPS         number of filter taps (>= 2)
//   CHANNELS     number of independent channels (>= 1)
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   bus          sample/result handshake (slave modport)
//   delay_clear  clear all channel delay lines (follows reset directly)
//   shift_en     push the captured sample into delay line ch_sel
//   acc_clear    zero the accumulator
//   mac_en       multiply tap tap_addr and accumulate
//   tap_addr     coefficient and delay-line index
//   ch_sel       channel currently processed (0 while idle)
//   ch_err       one-cycle pulse after an out-of-range channel is rejected
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fir_mc_controller #(
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    localparam int TAP_W   = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1,
    localparam int CH_W    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    fir_mc_controller_if.slave    bus,
    output logic                  delay_clear,
    output logic                  shift_en,
    output logic                  acc_clear,
    output logic                  mac_en,
    output logic [TAP_W-1:0]      tap_addr,
    output logic [CH_W-1:0]       ch_sel,
    output logic                  ch_err
);

    generate
        if (TAPS < 2) begin : g_taps_check
            $error("fir_mc_controller: TAPS must be at least 2");
        end
        if (CHANNELS < 1) begin : g_channels_check
            $error("fir_mc_controller: CHANNELS must be at least 1");
        end
    endgenerate

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    // One extra bit so that CHANNELS itself is representable when it is a
    // power of two (e.g. CHANNELS=2 with a 1-bit channel field).
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] count_q, count_d;
    logic [CH_W-1:0]  ch_q,    ch_d;
    logic             err_q,   err_d;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             shift_en_c;
    logic             acc_clear_c;
    logic             mac_en_c;
    logic [TAP_W-1:0] tap_addr_c;
    logic [CH_W-1:0]  ch_sel_c;
    logic [CH_W-1:0]  out_channel_c;
    logic             accept;
    logic             ch_bad;

    // State, tap counter, captured channel and error flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    assign ch_bad = ({1'b0, bus.in_channel} >= CH_LIMIT);

    // Next-state and output decode. Outputs come only from registered state,
    // count and channel; in_ready additionally looks at out_ready so a result
    // handoff and the next accept can share the same cycle.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        ch_d          = ch_q;
        err_d         = 1'b0;
        in_ready_c    = 1'b0;
        out_valid_c   = 1'b0;
        shift_en_c    = 1'b0;
        acc_clear_c   = 1'b0;
        mac_en_c      = 1'b0;
        tap_addr_c    = '0;
        ch_sel_c      = '0;
        out_channel_c = '0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
            end

            INIT: begin
                shift_en_c  = 1'b1;
                acc_clear_c = 1'b1;
                ch_sel_c    = ch_q;
                count_d     = '0;
                state_d     = MAC;
            end

            MAC: begin
                mac_en_c   = 1'b1;
                tap_addr_c = count_q;
                ch_sel_c   = ch_q;
                // Stop at the last tap rather than letting the counter wrap.
                if (count_q == LAST_TAP) begin
                    count_d = '0;
`ifdef FIR_CTRL_PIPE_MAC_EN
                    state_d = DRAIN;
`else
                    state_d = DONE;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

`ifdef FIR_CTRL_PIPE_MAC_EN
            // Lets the last product leave the multiplier register before the
            // accumulator is declared finished.
            DRAIN: begin
                ch_sel_c = ch_q;
                state_d  = DONE;
            end
`endif

            DONE: begin
                out_valid_c   = 1'b1;
                out_channel_c = ch_q;
                ch_sel_c      = ch_q;
                in_ready_c    = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept in DONE overrides the return to IDLE, so consecutive
        // samples run without an idle bubble.
        accept = bus.in_valid & in_ready_c;
        if (accept) begin
            if (ch_bad) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                ch_d    = bus.in_channel;
                state_d = INIT;
            end
        end
    end

    // Reset forces the strobes low at once and clears the delay lines
    // combinationally, before the synchronous reset edge lands.
    assign delay_clear     = reset;
    assign bus.in_ready    = in_ready_c  & ~reset;
    assign bus.out_valid   = out_valid_c & ~reset;
    assign bus.out_channel = out_channel_c;
    assign shift_en        = shift_en_c  & ~reset;
    assign acc_clear       = acc_clear_c & ~reset;
    assign mac_en          = mac_en_c    & ~reset;
    assign tap_addr        = tap_addr_c;
    assign ch_sel          = ch_sel_c;
    assign ch_err          = err_q       & ~reset;

endmodule
